// File: rtl/gisa_alu_pkg.sv
// Shared types and constants for the G.I.S.A. ALU normalizer.
// Holds the FSM state type, data/count widths and the per-stage shift-amount table.
package gisa_alu_pkg;

    localparam int unsigned W         = 32;
    localparam int unsigned CW        = 6;
    localparam int unsigned NumStages = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_t;

    // Binary-search step size for stage k: 16, 8, 4, 2, 1, then 0 past the last stage.
    function automatic logic [4:0] stage_amt(input logic [2:0] k);
        return 5'd16 >> k;
    endfunction

endpackage

// File: rtl/bit_normalizer_norm_stage.sv
// One binary-search step: tests whether the work value can be shifted by amt_i toward the
// normalized position and, if so, returns the shifted value with hit_o set.
module norm_stage
    import gisa_alu_pkg::*;
(
    input  logic [W-1:0] work_i,
    input  logic [4:0]   amt_i,
    input  logic         dir_i,
    input  logic         sgn_i,
    output logic [W-1:0] work_o,
    output logic         hit_o
);

    logic [W-1:0] top_mask;
    logic [W-1:0] sign_mask;
    logic [W-1:0] low_mask;
    logic [W-1:0] sign_diff;
    logic [5:0]   sign_amt;

    always_comb begin
        sign_amt  = {1'b0, amt_i} + 6'd1;
        top_mask  = ~({W{1'b1}} >> amt_i);
        // Sign mode inspects amt+1 bits so the retained MSB still matches the sign.
        sign_mask = ~({W{1'b1}} >> sign_amt);
        low_mask  = ~({W{1'b1}} << amt_i);
        sign_diff = work_i ^ {W{work_i[W-1]}};
        if (dir_i) begin
            hit_o  = (work_i & low_mask) == '0;
            work_o = work_i >> amt_i;
        end else if (sgn_i) begin
            hit_o  = (sign_diff & sign_mask) == '0;
            work_o = work_i << amt_i;
        end else begin
            hit_o  = (work_i & top_mask) == '0;
            work_o = work_i << amt_i;
        end
        if (!hit_o) begin
            work_o = work_i;
        end
    end

endmodule

// File: rtl/bit_normalizer.sv
// Multi-cycle CLZ/CTZ normalizer: returns the normalized value and the shift amount applied.
// Optional BIT_NORMALIZER_SIGNED_EN adds signed_sig for leading-sign-bit counting (left only).
module bit_normalizer
    import gisa_alu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  valA,
    input  logic          dir,
`ifdef BIT_NORMALIZER_SIGNED_EN
    input  logic          signed_sig,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic [CW-1:0] count,
    output logic          zero
);

    norm_state_t   state_q, state_d;
    logic [2:0]    stage_q, stage_d;
    logic [W-1:0]  work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          sgn_q, sgn_d;
    logic          zop_q, zop_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] count_q, count_d;
    logic          zero_q, zero_d;

    logic [4:0]    amt;
    logic [W-1:0]  stage_work;
    logic          stage_hit;
    logic          sgn_in;

`ifdef BIT_NORMALIZER_SIGNED_EN
    assign sgn_in = signed_sig & ~dir;
`else
    assign sgn_in = 1'b0;
`endif

    assign amt = stage_amt(stage_q);

    norm_stage u_norm_stage (
        .work_i (work_q),
        .amt_i  (amt),
        .dir_i  (dir_q),
        .sgn_i  (sgn_q),
        .work_o (stage_work),
        .hit_o  (stage_hit)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        sgn_d    = sgn_q;
        zop_d    = zop_q;
        result_d = result_q;
        count_d  = count_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = valA;
                    dir_d   = dir;
                    sgn_d   = sgn_in;
                    zop_d   = (valA == '0);
                    cnt_d   = '0;
                    stage_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (zop_q) begin
                    // Zero operand bypasses the search entirely.
                    result_d = '0;
                    count_d  = sgn_q ? 6'd31 : 6'd32;
                    zero_d   = 1'b1;
                    state_d  = DONE;
                end else if (stage_q == 3'(NumStages)) begin
                    // Extra cycle after the last stage loads the output registers.
                    result_d = work_q;
                    count_d  = cnt_q;
                    zero_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    if (stage_hit) begin
                        work_d = stage_work;
                        cnt_d  = cnt_q + {1'b0, amt};
                    end
                    stage_d = stage_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            sgn_q    <= 1'b0;
            zop_q    <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            sgn_q    <= sgn_d;
            zop_q    <= zop_d;
            result_q <= result_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign count     = count_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_bit_normalizer.sv
// Randomized self-checking bench for bit_normalizer against a bit-counting reference model.
// Signed-mode cases run only when BIT_NORMALIZER_SIGNED_EN is defined.
module tb_bit_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val_a;
    logic        dir;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [5:0]  count;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_normalizer dut (
        .clock      (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .valA       (val_a),
        .dir        (dir),
`ifdef BIT_NORMALIZER_SIGNED_EN
        .signed_sig (sgn),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .count      (count),
        .zero       (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: count zeros / redundant sign bits one bit position at a time.
    function automatic void model(input logic [31:0] a, input logic d, input logic s,
                                  output logic [31:0] r, output int c, output logic z);
        c = 0;
        if (a == 32'd0) begin
            r = 32'd0;
            z = 1'b1;
            c = (s && !d) ? 31 : 32;
        end else begin
            z = 1'b0;
            if (d) begin
                while (a[c] == 1'b0) c++;
                r = a >> c;
            end else if (s) begin
                while (c < 31 && a[30-c] == a[31]) c++;
                r = a << c;
            end else begin
                while (a[31-c] == 1'b0) c++;
                r = a << c;
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic d, input logic s, input int hold);
        logic [31:0] exp_r;
        int          exp_c;
        logic        exp_z;
        int          lat;
        model(a, d, s, exp_r, exp_c, exp_z);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        val_a    = a;
        dir      = d;
        sgn      = s;
        @(posedge clk);
        #1;
        // Keep in_valid high with garbage operands: must be ignored while busy.
        val_a = $urandom;
        dir   = $urandom_range(0, 1);
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            val_a = $urandom;
        end
        in_valid = 1'b0;
        check("latency", lat, (a == 32'd0) ? 32'd1 : 32'd6);
        check("result", result, exp_r);
        check("count", {26'd0, count}, exp_c);
        check("zero", {31'd0, zero}, {31'd0, exp_z});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_result", result, exp_r);
            check("hold_count", {26'd0, count}, exp_c);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic        s;
        reset     = 1'b1;
        in_valid  = 1'b0;
        val_a     = '0;
        dir       = 1'b0;
        sgn       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);

        run_op(32'h0001_0000, 1'b0, 1'b0, 0);
        run_op(32'h0001_0000, 1'b1, 1'b0, 0);
        run_op(32'h0000_0000, 1'b0, 1'b0, 0);
        run_op(32'h0000_0000, 1'b1, 1'b0, 1);
        run_op(32'h8000_0001, 1'b0, 1'b0, 3);
        run_op(32'h8000_0001, 1'b1, 1'b0, 3);
        run_op(32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 1'b1, 1'b0, 0);

        // Reset while the search is in progress drops the operation.
        @(negedge clk);
        in_valid = 1'b1;
        val_a    = 32'h0000_0F00;
        dir      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_count", {26'd0, count}, 32'd0);
        run_op(32'h0000_0F00, 1'b0, 1'b0, 0);

`ifdef BIT_NORMALIZER_SIGNED_EN
        run_op(32'hFFFF_0000, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        run_op(32'h0000_0000, 1'b0, 1'b1, 0);
        run_op(32'h0000_00FF, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_0000, 1'b1, 1'b1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            v = $urandom;
            v = v >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = v << $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) v = 32'd0;
            if ($urandom_range(0, 9) == 0) v = 32'hFFFF_FFFF;
`ifdef BIT_NORMALIZER_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(v, 1'($urandom_range(0, 1)), s, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
